mem_stage: RTL

Memory-access and write-back stage that consumes the execute stage's results. It latches a completed instruction (write-back value, ALU address, store data, destination register and control bits) and performs any load or store over a single-outstanding request/acknowledge data-memory bus. It then drives one register-file write and a one-cycle `fin` pulse back to the core sequencer. Byte and halfword accesses, lane steering, sign/zero extension and alignment checking are handled locally.

---
 rtl/mem_stage.sv | 191 +++++++++++++++++++
 1 files changed

// File: rtl/mem_stage.sv
`default_nettype none
// ============================================================================
// Module      : mem_stage
// Description : Memory-access / write-back stage. Latches one completed
//               instruction, runs at most one load or store over a
//               request/acknowledge data bus with byte-lane steering,
//               extension and alignment checking, then issues a single
//               register-file write together with a one-cycle fin pulse.
// Revision    : 1.0 - initial release
// ============================================================================
module mem_stage #(
    parameter int ADDR_WIDTH = 32
) (
    input  logic                  clk,
    input  logic                  rstn,
    input  logic                  enable,
    input  logic [5:0]            rd,
    input  logic                  regwrite,
    input  logic                  memread,
    input  logic                  memwrite,
    input  logic [1:0]            size,
    input  logic                  ld_unsigned,
    input  logic [31:0]           aluresult,
    input  logic [31:0]           result,
    input  logic [31:0]           rdata1,
    output logic                  fin,
    output logic                  misalign,
    output logic [5:0]            wb_rd,
    output logic                  wb_we,
    output logic [31:0]           wb_data,
    output logic                  mem_req,
    output logic                  mem_we,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    output logic [3:0]            mem_wstrb,
    output logic [31:0]           mem_wdata,
    input  logic                  mem_ack,
    input  logic [31:0]           mem_rdata
);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_REQ  = 2'd1;
    localparam logic [1:0] S_WB   = 2'd2;

    logic [1:0]  r_state;
    logic [5:0]  r_rd;
    logic        r_regwrite;
    logic        r_is_load;
    logic [1:0]  r_size;
    logic        r_unsigned;
    logic [1:0]  r_lane;
    logic [31:0] r_result;

    logic        w_is_mem;
    logic        w_misalign;
    logic        w_wb_en;
    logic [3:0]  w_wstrb;
    logic [31:0] w_wdata;
    logic [7:0]  w_byte;
    logic [15:0] w_half;
    logic [31:0] w_ld_data;

    // A load wins when both memread and memwrite are set.
    assign w_is_mem = memread | memwrite;
    assign w_wb_en  = regwrite & (rd != 6'd0);

    // Alignment check on the incoming request; size 11 behaves as a word.
    always_comb begin
        w_misalign = 1'b0;
        case (size)
            2'b00:   w_misalign = 1'b0;
            2'b01:   w_misalign = aluresult[0];
            default: w_misalign = |aluresult[1:0];
        endcase
        w_misalign = w_misalign & w_is_mem;
    end

    // Store lane steering: replicate data across lanes, strobe the target bytes.
    always_comb begin
        w_wstrb = 4'b1111;
        w_wdata = rdata1;
        case (size)
            2'b00: begin
                w_wstrb = 4'b0001 << aluresult[1:0];
                w_wdata = {4{rdata1[7:0]}};
            end
            2'b01: begin
                w_wstrb = 4'b0011 << aluresult[1:0];
                w_wdata = {2{rdata1[15:0]}};
            end
            default: begin
                w_wstrb = 4'b1111;
                w_wdata = rdata1;
            end
        endcase
    end

    // Load extraction from the returned word using the latched lane and size.
    always_comb begin
        w_byte    = mem_rdata[7:0];
        w_half    = r_lane[1] ? mem_rdata[31:16] : mem_rdata[15:0];
        w_ld_data = mem_rdata;
        case (r_lane)
            2'd0:    w_byte = mem_rdata[7:0];
            2'd1:    w_byte = mem_rdata[15:8];
            2'd2:    w_byte = mem_rdata[23:16];
            default: w_byte = mem_rdata[31:24];
        endcase
        case (r_size)
            2'b00:   w_ld_data = r_unsigned ? {24'd0, w_byte} : {{24{w_byte[7]}}, w_byte};
            2'b01:   w_ld_data = r_unsigned ? {16'd0, w_half} : {{16{w_half[15]}}, w_half};
            default: w_ld_data = mem_rdata;
        endcase
    end

    // Sequencer: accept in IDLE, wait for ack in REQ, one write-back cycle in WB.
    always_ff @(posedge clk) begin
        if (!rstn) begin
            r_state    <= S_IDLE;
            r_rd       <= 6'd0;
            r_regwrite <= 1'b0;
            r_is_load  <= 1'b0;
            r_size     <= 2'd0;
            r_unsigned <= 1'b0;
            r_lane     <= 2'd0;
            r_result   <= 32'd0;
            fin        <= 1'b0;
            misalign   <= 1'b0;
            wb_rd      <= 6'd0;
            wb_we      <= 1'b0;
            wb_data    <= 32'd0;
            mem_req    <= 1'b0;
            mem_we     <= 1'b0;
            mem_addr   <= '0;
            mem_wstrb  <= 4'd0;
            mem_wdata  <= 32'd0;
        end else begin
            fin      <= 1'b0;
            misalign <= 1'b0;
            wb_we    <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (enable) begin
                        r_rd       <= rd;
                        r_regwrite <= regwrite;
                        r_is_load  <= memread;
                        r_size     <= size;
                        r_unsigned <= ld_unsigned;
                        r_lane     <= aluresult[1:0];
                        r_result   <= result;
                        if (!w_is_mem || w_misalign) begin
                            // Nothing to do on the bus: write back immediately.
                            fin      <= 1'b1;
                            misalign <= w_misalign;
                            wb_rd    <= rd;
                            wb_data  <= result;
                            wb_we    <= w_wb_en & ~w_misalign;
                            r_state  <= S_WB;
                        end else begin
                            mem_req   <= 1'b1;
                            mem_we    <= ~memread;
                            mem_addr  <= {aluresult[ADDR_WIDTH-1:2], 2'b00};
                            mem_wstrb <= memread ? 4'd0 : w_wstrb;
                            mem_wdata <= memread ? 32'd0 : w_wdata;
                            r_state   <= S_REQ;
                        end
                    end
                end
                S_REQ: begin
                    if (mem_ack) begin
                        mem_req   <= 1'b0;
                        mem_we    <= 1'b0;
                        mem_wstrb <= 4'd0;
                        fin       <= 1'b1;
                        wb_rd     <= r_rd;
                        wb_data   <= r_is_load ? w_ld_data : r_result;
                        wb_we     <= r_regwrite & (r_rd != 6'd0);
                        r_state   <= S_WB;
                    end
                end
                S_WB: begin
                    r_state <= S_IDLE;
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

endmodule
`default_nettype wire
